modexp_scheduler: RTL and testbench

//  Shares one exponent_modulus engine between NUM_REQ requesters (key-gen, sign, verify paths).

---
 rtl/modexp_sched_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/modexp_scheduler.sv | 154 +++++++++++++++
 tb/tb_modexp_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_sched_pkg.sv
// Shared types and constants for the modexp engine scheduler.
// Optional feature macro: MODEXP_SCHED_TIMEOUT_EN (WAIT watchdog + DRAIN state).
package modexp_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } state_t;

    localparam int MIN_MODULUS = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant.
// Reusable for any shared engine; no state is kept here.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               any_grant
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_grant && req[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/modexp_scheduler.sv
// Shares one modexp engine between NUM_REQ requesters, one op in flight.
// Optional feature macro: MODEXP_SCHED_TIMEOUT_EN (WAIT watchdog + DRAIN state).
module modexp_scheduler
    import modexp_sched_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] req_value_in,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] req_modulus_in,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] req_exponent_in,
    output logic [NUM_REQ-1:0]            req_ready_out,
    output logic [NUM_REQ-1:0]            resp_valid_out,
    input  logic [NUM_REQ-1:0]            resp_ready_in,
    output logic [WIDTH-1:0]              resp_value_out,
    output logic                          resp_err_out,
    output logic                          eng_ready_out,
    output logic [WIDTH-1:0]              eng_value_out,
    output logic [WIDTH-1:0]              eng_modulus_out,
    output logic [WIDTH-1:0]              eng_exponent_out,
    input  logic [WIDTH-1:0]              eng_value_in,
    input  logic                          eng_busy_in,
    input  logic                          eng_valid_in
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_t             state;
    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    id_q;
    logic [WIDTH-1:0]   val_q;
    logic [WIDTH-1:0]   mod_q;
    logic [WIDTH-1:0]   exp_q;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               any_grant;
    logic               accept;
    logic               bad_mod;

`ifdef MODEXP_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;
    logic             timed_out;
`endif

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req       (req_valid_in),
        .last_grant(last_grant),
        .grant     (grant),
        .grant_id  (grant_id),
        .any_grant (any_grant)
    );

    assign accept  = (state == IDLE) && !eng_busy_in && any_grant;
    assign bad_mod = req_modulus_in[grant_id] < WIDTH'(MIN_MODULUS);

    assign req_ready_out    = accept ? grant : '0;
    assign eng_value_out    = val_q;
    assign eng_modulus_out  = mod_q;
    assign eng_exponent_out = exp_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state          <= IDLE;
            last_grant     <= ID_W'(NUM_REQ - 1);
            id_q           <= '0;
            val_q          <= '0;
            mod_q          <= '0;
            exp_q          <= '0;
            resp_valid_out <= '0;
            resp_value_out <= '0;
            resp_err_out   <= 1'b0;
            eng_ready_out  <= 1'b0;
`ifdef MODEXP_SCHED_TIMEOUT_EN
            cnt            <= '0;
            timed_out      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        val_q      <= req_value_in[grant_id];
                        mod_q      <= req_modulus_in[grant_id];
                        exp_q      <= req_exponent_in[grant_id];
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                        if (bad_mod) begin
                            state          <= RESP;
                            resp_valid_out <= grant;
                            resp_value_out <= '0;
                            resp_err_out   <= 1'b1;
                        end else begin
                            state         <= ISSUE;
                            eng_ready_out <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    eng_ready_out <= 1'b0;
                    state         <= WAIT;
`ifdef MODEXP_SCHED_TIMEOUT_EN
                    cnt           <= '0;
`endif
                end
                WAIT: begin
                    if (eng_valid_in) begin
                        state          <= RESP;
                        resp_valid_out <= NUM_REQ'(1) << id_q;
                        resp_value_out <= eng_value_in;
                        resp_err_out   <= 1'b0;
                    end
`ifdef MODEXP_SCHED_TIMEOUT_EN
                    else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state          <= RESP;
                        resp_valid_out <= NUM_REQ'(1) << id_q;
                        resp_value_out <= '0;
                        resp_err_out   <= 1'b1;
                        timed_out      <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (resp_ready_in[id_q]) begin
                        resp_valid_out <= '0;
`ifdef MODEXP_SCHED_TIMEOUT_EN
                        // abandoned op may still be running: wait it out
                        state          <= timed_out ? DRAIN : IDLE;
                        timed_out      <= 1'b0;
`else
                        state          <= IDLE;
`endif
                    end
                end
`ifdef MODEXP_SCHED_TIMEOUT_EN
                DRAIN: begin
                    if (!eng_busy_in && !eng_valid_in) begin
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_scheduler.sv
// Directed bench for modexp_scheduler with a small behavioural engine stub.
// Timeout scenario runs only when MODEXP_SCHED_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_modexp_scheduler;

  localparam int W = 16;
  localparam int N = 4;

  logic            clk_in = 1'b0;
  logic            rst_n_in;
  logic [N-1:0]        req_valid_in;
  logic [N-1:0][W-1:0] req_value_in;
  logic [N-1:0][W-1:0] req_modulus_in;
  logic [N-1:0][W-1:0] req_exponent_in;
  logic [N-1:0]    req_ready_out;
  logic [N-1:0]    resp_valid_out;
  logic [N-1:0]    resp_ready_in;
  logic [W-1:0]    resp_value_out;
  logic            resp_err_out;
  logic            eng_ready_out;
  logic [W-1:0]    eng_value_out;
  logic [W-1:0]    eng_modulus_out;
  logic [W-1:0]    eng_exponent_out;
  logic [W-1:0]    eng_value_in;
  logic            eng_busy_in;
  logic            eng_valid_in;

  logic            stub_busy;
  logic            stub_valid;
  logic [W-1:0]    stub_value;
  logic [W-1:0]    stub_res;
  int              stub_cnt;
  logic            stub_hold;
  logic            stub_kill;
  logic            man_valid;
  logic [W-1:0]    man_value;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int base_p;

  assign eng_valid_in = stub_valid | man_valid;
  assign eng_value_in = man_valid ? man_value : stub_value;
  assign eng_busy_in  = stub_busy;

  always #5 clk_in = ~clk_in;

  modexp_scheduler #(
    .WIDTH(W),
    .NUM_REQ(N),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .req_valid_in(req_valid_in),
    .req_value_in(req_value_in),
    .req_modulus_in(req_modulus_in),
    .req_exponent_in(req_exponent_in),
    .req_ready_out(req_ready_out),
    .resp_valid_out(resp_valid_out),
    .resp_ready_in(resp_ready_in),
    .resp_value_out(resp_value_out),
    .resp_err_out(resp_err_out),
    .eng_ready_out(eng_ready_out),
    .eng_value_out(eng_value_out),
    .eng_modulus_out(eng_modulus_out),
    .eng_exponent_out(eng_exponent_out),
    .eng_value_in(eng_value_in),
    .eng_busy_in(eng_busy_in),
    .eng_valid_in(eng_valid_in)
  );

  function automatic logic [W-1:0] mexp(input logic [W-1:0] b,
                                        input logic [W-1:0] e,
                                        input logic [W-1:0] m);
    logic [31:0] r;
    logic [31:0] x;
    r = 32'(1) % 32'(m);
    x = 32'(b) % 32'(m);
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * x) % 32'(m);
      x = (x * x) % 32'(m);
    end
    return r[W-1:0];
  endfunction

  always @(posedge clk_in) begin
    stub_valid <= 1'b0;
    if (!rst_n_in) begin
      stub_busy  <= 1'b0;
      stub_cnt   <= 0;
      stub_value <= '0;
    end else if (stub_kill) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
    end else if (eng_ready_out) begin
      stub_busy <= 1'b1;
      stub_cnt  <= 3;
      stub_res  <= mexp(eng_value_out, eng_exponent_out,
                        eng_modulus_out);
    end else if (stub_busy && stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1 && !stub_hold) begin
        stub_valid <= 1'b1;
        stub_value <= stub_res;
        stub_busy  <= 1'b0;
      end
    end
  end

  always @(posedge clk_in) begin
    if (eng_ready_out) pulses <= pulses + 1;
  end

  task automatic ck(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_resp(input string tag);
    int n;
    n = 0;
    while (resp_valid_out == '0 && n < 100) begin
      tick();
      n++;
    end
    ck(tag, resp_valid_out !== '0);
  endtask

  task automatic set_req(input int i, input int b,
                         input int m, input int e);
    req_value_in[i]    = W'(b);
    req_modulus_in[i]  = W'(m);
    req_exponent_in[i] = W'(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] exp_val [N];
    int           order [5];
    exp_val = '{16'd4, 16'd9, 16'd3, 16'd12};
    order   = '{0, 1, 2, 3, 0};

    rst_n_in        = 1'b0;
    req_valid_in    = '0;
    req_value_in    = '0;
    req_modulus_in  = '0;
    req_exponent_in = '0;
    resp_ready_in   = '0;
    stub_hold       = 1'b0;
    stub_kill       = 1'b0;
    man_valid       = 1'b0;
    man_value       = '0;
    tick();
    tick();
    ck("rst_resp_valid", resp_valid_out === 4'b0000);
    ck("rst_eng_ready", eng_ready_out === 1'b0);
    ck("rst_err", resp_err_out === 1'b0);
    ck("rst_value", resp_value_out === 16'd0);
    ck("rst_eng_mod", eng_modulus_out === 16'd0);
    ck("rst_ready", req_ready_out === 4'b0000);
    rst_n_in = 1'b1;
    tick();

    base_p = pulses;
    set_req(0, 3, 7, 5);
    req_valid_in = 4'b0001;
    #1;
    ck("t1_ready", req_ready_out === 4'b0001);
    tick();
    req_valid_in = '0;
    ck("t1_eng_ready", eng_ready_out === 1'b1);
    ck("t1_eng_mod", eng_modulus_out === 16'd7);
    ck("t1_eng_exp", eng_exponent_out === 16'd5);
    tick();
    ck("t1_eng_ready_drop", eng_ready_out === 1'b0);
    wait_resp("t1_wait");
    ck("t1_resp_valid", resp_valid_out === 4'b0001);
    ck("t1_value", resp_value_out === 16'd5);
    ck("t1_err", resp_err_out === 1'b0);
    ck("t1_pulses", (pulses - base_p) == 1);
    resp_ready_in = 4'b0001;
    tick();
    resp_ready_in = '0;
    ck("t1_resp_drop", resp_valid_out === 4'b0000);

    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, i + 2, 13, 2);
    req_valid_in = 4'b1111;
    #1;
    ck("t2_ready0", req_ready_out === 4'b0001);
    for (int k = 0; k < 5; k++) begin
      wait_resp("t2_wait");
      ck("t2_grant", resp_valid_out === 4'(1 << order[k]));
      ck("t2_value", resp_value_out === exp_val[order[k]]);
      resp_ready_in = 4'(1 << order[k]);
      if (k == 4) req_valid_in = '0;
      tick();
      resp_ready_in = '0;
    end

    base_p = pulses;
    set_req(2, 5, 1, 3);
    req_valid_in = 4'b0100;
    #1;
    ck("t3_ready", req_ready_out === 4'b0100);
    tick();
    req_valid_in = '0;
    ck("t3_resp_valid", resp_valid_out === 4'b0100);
    ck("t3_err", resp_err_out === 1'b1);
    ck("t3_value", resp_value_out === 16'd0);
    ck("t3_no_issue", eng_ready_out === 1'b0);
    resp_ready_in = 4'b1011;
    tick();
    ck("t3_other_ack", resp_valid_out === 4'b0100);
    resp_ready_in = 4'b0100;
    tick();
    resp_ready_in = '0;
    ck("t3_drop", resp_valid_out === 4'b0000);
    ck("t3_pulses", (pulses - base_p) == 0);

    set_req(1, 9, 11, 0);
    req_valid_in = 4'b0010;
    tick();
    req_valid_in = '0;
    ck("t4_eng_exp", eng_exponent_out === 16'd0);
    ck("t4_eng_val", eng_value_out === 16'd9);
    wait_resp("t4_wait");
    for (int c = 0; c < 10; c++) begin
      ck("t4_hold_valid", resp_valid_out === 4'b0010);
      ck("t4_hold_value", resp_value_out === 16'd1);
      ck("t4_hold_err", resp_err_out === 1'b0);
      tick();
    end
    resp_ready_in = 4'b0010;
    tick();
    resp_ready_in = '0;
    ck("t4_drop", resp_valid_out === 4'b0000);

    set_req(3, 2, 5, 3);
    req_valid_in = 4'b1000;
    tick();
    req_valid_in = '0;
    tick();
    tick();
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    ck("t5_rst_resp", resp_valid_out === 4'b0000);
    ck("t5_rst_op", eng_value_out === 16'd0);
    man_valid = 1'b1;
    man_value = 16'h0bad;
    tick();
    man_valid = 1'b0;
    ck("t5_ignored", resp_valid_out === 4'b0000);
    tick();
    tick();
    ck("t5_ignored2", resp_valid_out === 4'b0000);
    ck("t5_value0", resp_value_out === 16'd0);
    set_req(0, 2, 5, 3);
    req_valid_in = 4'b0001;
    #1;
    ck("t5_ready", req_ready_out === 4'b0001);
    tick();
    req_valid_in = '0;
    wait_resp("t5_wait");
    ck("t5_resp_valid", resp_valid_out === 4'b0001);
    ck("t5_value", resp_value_out === 16'd3);
    resp_ready_in = 4'b0001;
    tick();
    resp_ready_in = '0;

`ifdef MODEXP_SCHED_TIMEOUT_EN
    stub_hold = 1'b1;
    set_req(1, 2, 5, 3);
    req_valid_in = 4'b0010;
    tick();
    req_valid_in = '0;
    tick();
    for (int c = 0; c < 7; c++) tick();
    ck("t6_pre_to", resp_valid_out === 4'b0000);
    tick();
    ck("t6_to_valid", resp_valid_out === 4'b0010);
    ck("t6_to_err", resp_err_out === 1'b1);
    ck("t6_to_value", resp_value_out === 16'd0);
    resp_ready_in = 4'b0010;
    tick();
    resp_ready_in = '0;
    req_valid_in = 4'b0001;
    set_req(0, 2, 5, 3);
    stub_kill = 1'b1;
    tick();
    stub_kill = 1'b0;
    ck("t6_drain_ready", req_ready_out === 4'b0000);
    tick();
    ck("t6_idle_ready", req_ready_out === 4'b0001);
    stub_hold = 1'b0;
    tick();
    req_valid_in = '0;
    wait_resp("t6_wait");
    ck("t6_value", resp_value_out === 16'd3);
    ck("t6_err", resp_err_out === 1'b0);
    resp_ready_in = 4'b0001;
    tick();
    resp_ready_in = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
